// File: rtl/wb_stage_pkg.sv
// wb_stage_pkg: shared datapath width and load funct3 encodings for the write-back stage
package wb_stage_pkg;
    localparam int XLEN = 64;
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;
endpackage

// File: rtl/wb_load_ext.sv
// wb_load_ext: selects the addressed byte/half/word of a loaded doubleword and extends it
module wb_load_ext #(
    parameter int XLEN = wb_stage_pkg::XLEN
) (
    input  logic [2:0]      i_funct3,
    input  logic [2:0]      i_off,
    input  logic [XLEN-1:0] i_rdata,
    output logic [XLEN-1:0] o_res
);
    import wb_stage_pkg::*;

    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] w;

    // offset bits below the access size are dropped by the lane selects
    always_comb begin
        b = i_rdata[{i_off, 3'b000} +: 8];
        h = i_rdata[{i_off[2:1], 4'b0000} +: 16];
        w = i_rdata[{i_off[2], 5'b00000} +: 32];
        case (i_funct3)
            F3_LB:   o_res = {{(XLEN-8){b[7]}}, b};
            F3_LBU:  o_res = XLEN'(b);
            F3_LH:   o_res = {{(XLEN-16){h[15]}}, h};
            F3_LHU:  o_res = XLEN'(h);
            F3_LW:   o_res = {{(XLEN-32){w[31]}}, w};
            F3_LWU:  o_res = XLEN'(w);
            F3_LD:   o_res = i_rdata;
            default: o_res = '0;
        endcase
    end
endmodule

// File: rtl/wb_stage.sv
// wb_stage: RV64 write-back stage; optional difftest commit ports under WB_COMMIT_TRACE_EN
module wb_stage #(
    parameter int XLEN      = wb_stage_pkg::XLEN,
    parameter int INSTRET_W = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [XLEN-1:0]      i_pc,
    input  logic [31:0]          i_inst,
    input  logic                 i_rd_wen,
    input  logic [4:0]           i_rd_addr,
    input  logic [XLEN-1:0]      i_alu_res,
    input  logic                 i_is_load,
    input  logic [2:0]           i_load_funct3,
    input  logic [XLEN-1:0]      i_mem_rdata,
    input  logic                 i_stall,
    output logic                 o_wen,
    output logic [4:0]           o_waddr,
    output logic [XLEN-1:0]      o_wdata,
    output logic [INSTRET_W-1:0] o_instret
`ifdef WB_COMMIT_TRACE_EN
    ,
    output logic                 o_commit_valid,
    output logic [XLEN-1:0]      o_commit_pc,
    output logic [31:0]          o_commit_inst,
    output logic                 o_commit_wen
`endif
);
    import wb_stage_pkg::*;

    logic                 valid_q, valid_d, rd_wen_q, rd_wen_d, is_load_q, is_load_d;
    logic [4:0]           rd_q, rd_d;
    logic [2:0]           funct3_q, funct3_d;
    logic [XLEN-1:0]      alu_res_q, alu_res_d, rdata_q, rdata_d, ext_res, result;
    logic [INSTRET_W-1:0] instret_q, instret_d;
    logic                 accept, retire;

    wb_load_ext #(.XLEN(XLEN)) u_load_ext (
        .i_funct3(funct3_q),
        .i_off   (alu_res_q[2:0]),
        .i_rdata (rdata_q),
        .o_res   (ext_res)
    );

    // handshake: a retiring entry frees the slot in the same cycle a new one is accepted
    always_comb begin
        o_ready   = ~valid_q | ~i_stall;
        accept    = i_valid & o_ready;
        retire    = valid_q & ~i_stall;
        valid_d   = accept | (valid_q & ~retire);
        rd_wen_d  = accept ? i_rd_wen      : rd_wen_q;
        rd_d      = accept ? i_rd_addr     : rd_q;
        alu_res_d = accept ? i_alu_res     : alu_res_q;
        is_load_d = accept ? i_is_load     : is_load_q;
        funct3_d  = accept ? i_load_funct3 : funct3_q;
        rdata_d   = accept ? i_mem_rdata   : rdata_q;
        instret_d = instret_q + INSTRET_W'(retire);
    end

    // register-file port; wen only on the retiring cycle so a stall yields one pulse
    always_comb begin
        result    = is_load_q ? ext_res : alu_res_q;
        o_wen     = retire & rd_wen_q & (rd_q != 5'd0);
        o_waddr   = valid_q ? rd_q : 5'd0;
        o_wdata   = valid_q ? result : '0;
        o_instret = instret_q;
    end

    // pipeline register and retire counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            rd_wen_q  <= 1'b0;
            rd_q      <= '0;
            alu_res_q <= '0;
            is_load_q <= 1'b0;
            funct3_q  <= '0;
            rdata_q   <= '0;
            instret_q <= '0;
        end else begin
            valid_q   <= valid_d;
            rd_wen_q  <= rd_wen_d;
            rd_q      <= rd_d;
            alu_res_q <= alu_res_d;
            is_load_q <= is_load_d;
            funct3_q  <= funct3_d;
            rdata_q   <= rdata_d;
            instret_q <= instret_d;
        end
    end

`ifdef WB_COMMIT_TRACE_EN
    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     inst_q, inst_d;

    // commit trace mirrors the retire and write-enable of the held instruction
    always_comb begin
        pc_d           = accept ? i_pc : pc_q;
        inst_d         = accept ? i_inst : inst_q;
        o_commit_valid = retire;
        o_commit_pc    = valid_q ? pc_q : '0;
        o_commit_inst  = valid_q ? inst_q : '0;
        o_commit_wen   = o_wen;
    end

    // trace payload registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q   <= '0;
            inst_q <= '0;
        end else begin
            pc_q   <= pc_d;
            inst_q <= inst_d;
        end
    end
`else
    logic unused_trace;
    assign unused_trace = ^{i_pc, i_inst};
`endif
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed plus random checks of wb_stage against a behavioural model
module tb_wb_stage;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        i_valid = 1'b0, i_rd_wen = 1'b0, i_is_load = 1'b0, i_stall = 1'b0;
    logic [63:0] i_pc = '0, i_alu_res = '0, i_mem_rdata = '0;
    logic [31:0] i_inst = '0;
    logic [4:0]  i_rd_addr = '0;
    logic [2:0]  i_load_funct3 = '0;
    logic        o_ready, o_wen;
    logic [4:0]  o_waddr;
    logic [63:0] o_wdata, o_instret;
`ifdef WB_COMMIT_TRACE_EN
    logic        o_commit_valid, o_commit_wen;
    logic [63:0] o_commit_pc;
    logic [31:0] o_commit_inst;
`endif

    int total = 0, bad = 0;
    logic        m_valid = 1'b0, m_wen = 1'b0;
    logic [4:0]  m_rd = '0;
    logic [63:0] m_res = '0, m_instret = '0;

    always #5 clk = ~clk;

    wb_stage dut (
        .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready), .i_pc(i_pc),
        .i_inst(i_inst), .i_rd_wen(i_rd_wen), .i_rd_addr(i_rd_addr), .i_alu_res(i_alu_res),
        .i_is_load(i_is_load), .i_load_funct3(i_load_funct3), .i_mem_rdata(i_mem_rdata),
        .i_stall(i_stall), .o_wen(o_wen), .o_waddr(o_waddr), .o_wdata(o_wdata),
        .o_instret(o_instret)
`ifdef WB_COMMIT_TRACE_EN
        , .o_commit_valid(o_commit_valid), .o_commit_pc(o_commit_pc),
        .o_commit_inst(o_commit_inst), .o_commit_wen(o_commit_wen)
`endif
    );

    function automatic logic [63:0] ref_result(input logic ld, input logic [2:0] f3,
                                                input logic [63:0] alu, input logic [63:0] rdata);
        int size, off;
        logic [63:0] mask, v;
        if (!ld) return alu;
        if (f3 == 3'b111) return 64'd0;
        size = 1 << f3[1:0];
        off  = (int'(alu[2:0]) / size) * size;
        mask = (size == 8) ? '1 : ((64'd1 << (size * 8)) - 64'd1);
        v    = (rdata >> (off * 8)) & mask;
        if (!f3[2] && size < 8 && v[size*8-1]) v = v | ~mask;
        return v;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input string tag);
        chk({tag, " ready"}, 64'(o_ready), 64'(!m_valid || !i_stall));
        chk({tag, " wen"}, 64'(o_wen), 64'(m_valid && !i_stall && m_wen && m_rd != 5'd0));
        chk({tag, " waddr"}, 64'(o_waddr), m_valid ? 64'(m_rd) : 64'd0);
        chk({tag, " wdata"}, o_wdata, m_valid ? m_res : 64'd0);
        chk({tag, " instret"}, o_instret, m_instret);
    endtask

    task automatic drive(input logic v, input logic wen, input logic [4:0] rd, input logic [63:0] alu,
                         input logic ld, input logic [2:0] f3, input logic [63:0] rdata, input logic st);
        i_valid = v; i_rd_wen = wen; i_rd_addr = rd; i_alu_res = alu;
        i_is_load = ld; i_load_funct3 = f3; i_mem_rdata = rdata; i_stall = st;
        i_pc = {32'd0, $urandom}; i_inst = $urandom;
        #1;
    endtask

    task automatic tick();
        logic acc, ret;
        acc = i_valid && (!m_valid || !i_stall);
        ret = m_valid && !i_stall;
        @(posedge clk);
        #1;
        if (ret) m_instret = m_instret + 64'd1;
        if (acc) begin
            m_valid = 1'b1; m_rd = i_rd_addr; m_wen = i_rd_wen;
            m_res = ref_result(i_is_load, i_load_funct3, i_alu_res, i_mem_rdata);
        end else if (ret) m_valid = 1'b0;
    endtask

    initial begin
        #12;
        check_outs("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        drive(1, 1, 5'd5, 64'h1234, 0, 3'b000, 64'd0, 0);
        i_pc = 64'h8000_0000;
        check_outs("alu accept");
        tick();
        drive(0, 0, 5'd0, 64'd0, 0, 3'b000, 64'd0, 0);
        check_outs("alu retire");
        chk("alu wen", 64'(o_wen), 64'd1);
        chk("alu waddr", 64'(o_waddr), 64'd5);
        chk("alu wdata", o_wdata, 64'h1234);
        tick();
        chk("alu instret", o_instret, 64'd1);

        drive(1, 1, 5'd3, 64'h1001, 1, 3'b000, 64'h80FF, 0);
        tick();
        chk("lb wdata", o_wdata, 64'hFFFF_FFFF_FFFF_FF80);
        drive(1, 1, 5'd3, 64'h1001, 1, 3'b100, 64'h80FF, 0);
        check_outs("lb");
        tick();
        chk("lbu wdata", o_wdata, 64'h80);
        drive(1, 1, 5'd4, 64'h2004, 1, 3'b010, 64'h8765_4321_0000_0000, 0);
        check_outs("lbu");
        tick();
        chk("lw wdata", o_wdata, 64'hFFFF_FFFF_8765_4321);
        drive(1, 1, 5'd4, 64'h2004, 1, 3'b110, 64'h8765_4321_0000_0000, 0);
        check_outs("lw");
        tick();
        chk("lwu wdata", o_wdata, 64'h0000_0000_8765_4321);
        drive(1, 1, 5'd0, 64'hDEAD, 0, 3'b000, 64'd0, 0);
        check_outs("lwu");
        tick();
        drive(0, 0, 5'd0, 64'd0, 0, 3'b000, 64'd0, 0);
        chk("x0 wen", 64'(o_wen), 64'd0);
        check_outs("x0");
        tick();
        chk("x0 instret", o_instret, 64'd6);

        drive(1, 1, 5'd7, 64'h77, 0, 3'b000, 64'd0, 0);
        tick();
        for (int k = 0; k < 3; k++) begin
            drive(1, 1, 5'd9, 64'h99, 0, 3'b000, 64'd0, 1);
            chk("stall ready", 64'(o_ready), 64'd0);
            chk("stall wen", 64'(o_wen), 64'd0);
            check_outs("stall");
            tick();
        end
        drive(1, 1, 5'd9, 64'h99, 0, 3'b000, 64'd0, 0);
        chk("release wen", 64'(o_wen), 64'd1);
        chk("release ready", 64'(o_ready), 64'd1);
        chk("release waddr", 64'(o_waddr), 64'd7);
        tick();
        drive(0, 0, 5'd0, 64'd0, 0, 3'b000, 64'd0, 0);
        chk("next waddr", 64'(o_waddr), 64'd9);
        check_outs("next");
        tick();
        chk("stall instret", o_instret, 64'd8);

        for (int k = 0; k < 400; k++) begin
            drive(($urandom_range(0, 3) != 0), $urandom_range(0, 1), 5'($urandom_range(0, 31)),
                  {$urandom, $urandom}, $urandom_range(0, 1), 3'($urandom_range(0, 7)),
                  {$urandom, $urandom}, ($urandom_range(0, 2) == 0));
            check_outs("rand");
            tick();
        end

        drive(1, 1, 5'd7, 64'h55, 0, 3'b000, 64'd0, 0);
        tick();
        drive(0, 0, 5'd0, 64'd0, 0, 3'b000, 64'd0, 1);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        m_valid = 1'b0; m_instret = '0;
        chk("async wen", 64'(o_wen), 64'd0);
        chk("async waddr", 64'(o_waddr), 64'd0);
        chk("async ready", 64'(o_ready), 64'd1);
        chk("async instret", o_instret, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 0, 5'd0, 64'd0, 0, 3'b000, 64'd0, 0);
        tick();
        check_outs("post reset");
        tick();
        check_outs("post reset 2");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
